// File: rtl/cv32e40p_alu_fault_monitor.sv
// Health monitor behind the TMR ALU voter: OK/SUSPECT/PERMANENT classification, sticky flags, irq.
// Optional per-group saturating event counters and alarm source under `CV32E40P_ALU_FAULT_CNT_EN.
module cv32e40p_alu_fault_monitor #(
    parameter int CNT_WIDTH    = 16,
    parameter int PERM_THRESH  = 4,
    parameter int ALARM_THRESH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [2:0]             faulty_i,
    input  logic                   clear_i,
    input  logic                   irq_ack_i,
    output logic [1:0]             state_o,
    output logic [2:0]             sticky_o,
    output logic [3*CNT_WIDTH-1:0] fault_cnt_o,
    output logic                   perm_fault_o,
    output logic                   irq_o
);

    localparam int RUN_W = $clog2(PERM_THRESH + 1);

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_PERM    = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       sticky_q;
    logic             perm_q;
    logic             irq_q;
    logic             perm_evt;
    logic             alarm_evt;
    logic             samp_fault;
    logic             samp_clean;

    assign samp_fault = en_i & (|faulty_i);
    assign samp_clean = en_i & ~(|faulty_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            run_q   <= '0;
            perm_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            perm_q  <= (state_d == ST_PERM);
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        perm_evt = 1'b0;
        if (samp_fault) begin
            run_d = (run_q >= RUN_W'(PERM_THRESH)) ? RUN_W'(PERM_THRESH) : run_q + 1'b1;
        end else if (samp_clean) begin
            run_d = '0;
        end
        case (state_q)
            ST_OK: begin
                if (samp_fault) begin
                    state_d = ST_SUSPECT;
                    run_d   = RUN_W'(1);
                end
            end
            ST_SUSPECT: begin
                if (samp_clean) begin
                    state_d = ST_OK;
                end else if (samp_fault && (run_q >= RUN_W'(PERM_THRESH - 1))) begin
                    state_d  = ST_PERM;
                    perm_evt = 1'b1;
                end
            end
            ST_PERM: ;
            default: state_d = ST_OK;
        endcase
        // Clear wins over any fault sampled in the same cycle.
        if (clear_i) begin
            state_d  = ST_OK;
            run_d    = '0;
            perm_evt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (clear_i) begin
            sticky_q <= '0;
        end else if (en_i) begin
            sticky_q <= sticky_q | faulty_i;
        end
    end

`ifdef CV32E40P_ALU_FAULT_CNT_EN
    logic [2:0] alarm_hit;

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clear_i) begin
                cnt_q <= '0;
            end else if (en_i && faulty_i[g] && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // One-shot: only the exact step onto the threshold raises the alarm.
        assign alarm_hit[g] = en_i & faulty_i[g] & ~clear_i &
                              (cnt_q == CNT_WIDTH'(ALARM_THRESH - 1));
        assign fault_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

    assign alarm_evt = |alarm_hit;
`else
    logic unused_alarm_thresh;

    assign unused_alarm_thresh = ALARM_THRESH[0];
    assign fault_cnt_o         = '0;
    assign alarm_evt           = 1'b0;
`endif

    // A new event in the ack cycle keeps the interrupt asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (clear_i) begin
            irq_q <= 1'b0;
        end else if (perm_evt || alarm_evt) begin
            irq_q <= 1'b1;
        end else if (irq_ack_i) begin
            irq_q <= 1'b0;
        end
    end

    assign state_o      = state_q;
    assign sticky_o     = sticky_q;
    assign perm_fault_o = perm_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_cv32e40p_alu_fault_monitor.sv
// Directed bench for cv32e40p_alu_fault_monitor: default instance plus a narrow-counter instance.
module tb_cv32e40p_alu_fault_monitor;

`ifdef CV32E40P_ALU_FAULT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, ack;
    logic [2:0]  flt;
    logic [1:0]  st;
    logic [2:0]  sticky;
    logic [47:0] cnt;
    logic        pf, irq;

    logic        en2, clr2, ack2;
    logic [2:0]  flt2;
    logic [1:0]  st2;
    logic [2:0]  sticky2;
    logic [5:0]  cnt2;
    logic        pf2, irq2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cv32e40p_alu_fault_monitor dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .faulty_i(flt), .clear_i(clr),
        .irq_ack_i(ack), .state_o(st), .sticky_o(sticky), .fault_cnt_o(cnt),
        .perm_fault_o(pf), .irq_o(irq)
    );

    cv32e40p_alu_fault_monitor #(.CNT_WIDTH(2), .PERM_THRESH(4), .ALARM_THRESH(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .en_i(en2), .faulty_i(flt2), .clear_i(clr2),
        .irq_ack_i(ack2), .state_o(st2), .sticky_o(sticky2), .fault_cnt_o(cnt2),
        .perm_fault_o(pf2), .irq_o(irq2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ce(input int v);
        return CNT_EN ? 64'(v) : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] f, input logic c, input logic a);
        en = e; flt = f; clr = c; ack = a;
    endtask

    task automatic drive2(input logic e, input logic [2:0] f, input logic a);
        en2 = e; flt2 = f; clr2 = 1'b0; ack2 = a;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 3'b000, 0, 0);
        drive2(0, 3'b000, 0);
        #3;
        chk("rst_state", 64'(st), 64'd0);
        chk("rst_sticky", 64'(sticky), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_pf", 64'(pf), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Transient faults on group 0, then recovery
        drive(1, 3'b001, 0, 0);
        tick(); chk("t1_st1", 64'(st), 64'd1); chk("t1_cnt1", 64'(cnt[15:0]), ce(1));
        tick(); chk("t1_st2", 64'(st), 64'd1);
        tick(); chk("t1_st3", 64'(st), 64'd1); chk("t1_cnt3", 64'(cnt[15:0]), ce(3));
        drive(1, 3'b000, 0, 0);
        tick();
        chk("t1_st_ok", 64'(st), 64'd0);
        chk("t1_sticky", 64'(sticky), 64'd1);
        chk("t1_cnt_final", 64'(cnt), ce(3));
        chk("t1_irq", 64'(irq), 64'd0);
        chk("t1_pf", 64'(pf), 64'd0);

        // Unqualified fault is ignored
        drive(0, 3'b111, 0, 0);
        tick();
        chk("noen_st", 64'(st), 64'd0);
        chk("noen_sticky", 64'(sticky), 64'd1);
        chk("noen_cnt", 64'(cnt), ce(3));
        chk("noen_irq", 64'(irq), 64'd0);

        // Group 1 alarm: 8 faults interleaved with clean cycles
        for (int i = 1; i <= 8; i++) begin
            drive(1, 3'b010, 0, 0);
            tick();
            chk("g1_st_fault", 64'(st), 64'd1);
            if (i == 7) chk("g1_irq_pre", 64'(irq), 64'd0);
            drive(1, 3'b000, 0, 0);
            tick();
            chk("g1_st_clean", 64'(st), 64'd0);
        end
        chk("g1_irq", 64'(irq), 64'(CNT_EN));
        chk("g1_cnt", 64'(cnt[31:16]), ce(8));
        chk("g1_sticky", 64'(sticky), 64'd3);
        drive(0, 3'b000, 0, 1);
        tick();
        chk("g1_ack", 64'(irq), 64'd0);
        drive(1, 3'b010, 0, 0);
        tick();
        chk("g1_nine_irq", 64'(irq), 64'd0);
        chk("g1_nine_cnt", 64'(cnt[31:16]), ce(9));
        drive(1, 3'b000, 0, 0);
        tick();
        chk("g1_back_ok", 64'(st), 64'd0);

        // Permanent fault on group 2
        drive(1, 3'b100, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("p_st_suspect", 64'(st), 64'd1);
            chk("p_pf_low", 64'(pf), 64'd0);
            chk("p_irq_low", 64'(irq), 64'd0);
        end
        tick();
        chk("p_st_perm", 64'(st), 64'd2);
        chk("p_pf", 64'(pf), 64'd1);
        chk("p_irq", 64'(irq), 64'd1);
        chk("p_sticky", 64'(sticky), 64'd7);
        chk("p_cnt2", 64'(cnt[47:32]), ce(4));
        drive(1, 3'b000, 0, 0);
        tick(); tick();
        chk("p_hold_st", 64'(st), 64'd2);
        chk("p_hold_pf", 64'(pf), 64'd1);
        chk("p_hold_irq", 64'(irq), 64'd1);
        drive(1, 3'b000, 0, 1);
        tick();
        chk("p_ack_irq", 64'(irq), 64'd0);
        chk("p_ack_st", 64'(st), 64'd2);

        // Clear with simultaneous faults in PERMANENT
        drive(1, 3'b111, 1, 0);
        tick();
        chk("clr_st", 64'(st), 64'd0);
        chk("clr_sticky", 64'(sticky), 64'd0);
        chk("clr_cnt", 64'(cnt), 64'd0);
        chk("clr_pf", 64'(pf), 64'd0);
        chk("clr_irq", 64'(irq), 64'd0);

        // Run count restarts after clear: 3 faults stay SUSPECT, 4th goes PERMANENT
        drive(1, 3'b001, 0, 0);
        tick(); tick(); tick();
        chk("rc_st3", 64'(st), 64'd1);
        tick();
        chk("rc_st4", 64'(st), 64'd2);
        chk("rc_irq4", 64'(irq), 64'd1);

        // Asynchronous reset while PERMANENT
        drive(0, 3'b000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_st", 64'(st), 64'd0);
        chk("arst_pf", 64'(pf), 64'd0);
        chk("arst_irq", 64'(irq), 64'd0);
        chk("arst_sticky", 64'(sticky), 64'd0);
        chk("arst_cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Narrow counters: CNT_WIDTH=2, ALARM_THRESH=3
        for (int i = 1; i <= 5; i++) begin
            drive2(1, 3'b100, 0);
            tick();
            chk("n_cnt", 64'(cnt2[5:4]), ce(i > 3 ? 3 : i));
            chk("n_irq", 64'(irq2), (i == 3) ? 64'(CNT_EN) : 64'd0);
            drive2(1, 3'b000, (i == 3) ? 1'b1 : 1'b0);
            tick();
            chk("n_st_clean", 64'(st2), 64'd0);
            if (i == 3) chk("n_ack", 64'(irq2), 64'd0);
        end
        chk("n_pf", 64'(pf2), 64'd0);
        chk("n_sticky", 64'(sticky2), 64'd4);
        chk("n_other_cnt", 64'(cnt2[3:0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_alu_fault_monitor.md
# cv32e40p_alu_fault_monitor

Sequential fault monitor directly downstream of the TMR ALU voter. It samples the voter's three per-output `faulty` flags (result, cmp_result, ready) on qualified cycles. It classifies the ALU as healthy, suspect (transient) or permanently faulty, and keeps sticky per-group flags and saturating per-group event counters. It raises a level interrupt, held until acknowledged, for the controller / CSR logic.

## Interface
- `CNT_WIDTH`, 16: width of each per-group event counter.
- `PERM_THRESH`, 4: consecutive sampled fault cycles needed to declare a permanent fault. Must be >= 2.
- `ALARM_THRESH`, 8: per-group count value that fires an alarm interrupt. Must be in 1..2^CNT_WIDTH-1.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  sample qualifier (ALU operation valid this cycle).
- `faulty_i`  in  3  voter flags: [0] result, [1] cmp_result, [2] ready.
- `clear_i`  in  1  synchronous clear of the FSM, sticky flags, counters and irq.
- `irq_ack_i`  in  1  interrupt acknowledge.
- `state_o`  out  2  FSM state: 00 OK, 01 SUSPECT, 10 PERMANENT.
- `sticky_o`  out  3  per-group sticky fault flags.
- `fault_cnt_o`  out  3*CNT_WIDTH  packed per-group counters; group g occupies bits [g*CNT_WIDTH +: CNT_WIDTH].
- `perm_fault_o`  out  1  high while state is PERMANENT.
- `irq_o`  out  1  level interrupt.

## Operation
- Sampled fault: `en_i & |faulty_i`. Sampled clean: `en_i & ~|faulty_i`. Cycles with `en_i`=0 change nothing.
- Sticky: `sticky_o[g]` is set on a sampled cycle with `faulty_i[g]`=1. It holds until `clear_i`.
- Counters: on a sampled cycle, each group with `faulty_i[g]`=1 increments by 1. Counters saturate at all-ones and never wrap.
- Run counter (internal, width $clog2(PERM_THRESH+1)):
  - increments on a sampled fault;
  - resets to 0 on a sampled clean;
  - saturates at PERM_THRESH.
- FSM transitions:
  - OK → SUSPECT on a sampled fault; run count becomes 1.
  - SUSPECT → OK on a sampled clean.
  - SUSPECT → PERMANENT on the sampled fault that brings the run count to PERM_THRESH.
  - PERMANENT holds regardless of inputs. It is left only via `clear_i` or reset.
  - State encoding 11 is unreachable. If it is ever decoded, the FSM goes to OK.
- Interrupt events:
  - the transition into PERMANENT;
  - any group counter stepping from ALARM_THRESH-1 to ALARM_THRESH. This is a one-shot event and does not re-fire while the counter saturates.
- `irq_o` sets on an event and clears the cycle after `irq_ack_i`, unless a new event arrives in the same cycle as the ack. In that case `irq_o` stays 1.
- `clear_i` priority: `clear_i` overrides everything in its cycle. The FSM goes to OK; run count, sticky flags, counters and `irq_o` go to 0. Faults sampled in the same cycle are discarded.

## Timing
- All outputs are registered. An input in cycle N is reflected in the outputs at the edge ending cycle N, i.e. visible in cycle N+1.
- Reset (`rst_n`=0, asynchronous): state_o=00, sticky_o=0, fault_cnt_o=0, perm_fault_o=0, irq_o=0, run count=0.
- Reset mid-run, including in PERMANENT, returns every output to its reset value immediately. No history is retained.
- `perm_fault_o` and `irq_o` rise in the same cycle as `state_o`=10.
- The ack takes one cycle: ack in cycle N gives `irq_o`=0 in cycle N+1.
- No combinational path from any input to any output.

## Configuration
- `CV32E40P_ALU_FAULT_CNT_EN`
  - Defined: per-group event counters and the ALARM_THRESH interrupt source are present.
  - Undefined: counters are removed, `fault_cnt_o` is tied to 0, and the only interrupt source is entry into PERMANENT.
  - FSM, sticky flags and run counter are identical in both builds.

## Test plan
- Reset, then 3 sampled cycles with faulty_i=3'b001 followed by 1 clean cycle → state OK→SUSPECT→SUSPECT→SUSPECT→OK; sticky_o=001; cnt[0]=3; irq_o stays 0.
- 4 consecutive sampled cycles with faulty_i=3'b100 → state_o=10, perm_fault_o=1, irq_o=1 in the cycle after the 4th fault; later clean cycles keep PERMANENT.
- 8 sampled faults on group 1, interleaved with clean cycles → irq_o=1 the cycle after the 8th; ack → irq_o=0 next cycle; a 9th fault does not re-fire.
- Fault with en_i=0 (faulty_i=3'b111) → no change to any output.
- clear_i with faulty_i=3'b111 and en_i=1 in PERMANENT → next cycle all outputs 0, state_o=00.
- With CNT_WIDTH=2 and ALARM_THRESH=3, 5 faults on group 2 → cnt[2] holds at 3; irq fires once. Build without the macro → fault_cnt_o=0 throughout and irq_o fires only on PERMANENT.
